// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM port arbiter.
package ram_ctrl_pkg;

  localparam int unsigned AW_DEF = 3;
  localparam int unsigned DW_DEF = 3;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester, clear-control and RAM-side signals of the two-port RAM arbiter.
interface ram_port_arbiter_if
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic          a_rvalid;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic          b_rvalid;
  logic [DW-1:0] b_rdata;

  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    input  clr_req,
    output clr_busy, clr_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    output clr_req,
    input  clr_busy, clr_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer remembers the last winner.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  sel_e last_q;

  // Reset to B so that A wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= SEL_B;
    end else if (|gnt) begin
      last_q <= gnt[1] ? SEL_B : SEL_A;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == SEL_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous-read RAM port between two requesters and runs a
// full-RAM zero-fill sequence on request.
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
)(
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt;
  logic          a_rv_q, b_rv_q;

  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          clr_busy, clr_done;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.b_req, bus.a_req}),
    .advance (state_q == RUN),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_rv_q  <= gnt[0] & ~bus.a_we;
      b_rv_q  <= gnt[1] & ~bus.b_we;
    end
  end

  // Next state plus the RAM strobe: winner's access in RUN, zero-fill in CLEAR.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    case (state_q)
      RUN: begin
        if (gnt[0]) begin
          mem_en    = 1'b1;
          mem_we    = bus.a_we;
          mem_addr  = bus.a_addr;
          mem_wdata = bus.a_wdata;
        end else if (gnt[1]) begin
          mem_en    = 1'b1;
          mem_we    = bus.b_we;
          mem_addr  = bus.b_addr;
          mem_wdata = bus.b_wdata;
        end
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = cnt_q;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == LAST_ADDR) begin
          clr_done = 1'b1;
          state_d  = RUN;
          cnt_d    = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.a_gnt     = gnt[0];
  assign bus.b_gnt     = gnt[1];
  assign bus.a_rvalid  = a_rv_q;
  assign bus.b_rvalid  = b_rv_q;
  assign bus.a_rdata   = a_rv_q ? bus.mem_rdata : '0;
  assign bus.b_rdata   = b_rv_q ? bus.mem_rdata : '0;
  assign bus.clr_busy  = clr_busy;
  assign bus.clr_done  = clr_done;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural synchronous-read RAM.
module tb_ram_port_arbiter;

  logic clk;
  logic rst;
  logic ram_load;
  int   checks;
  int   failures;

  logic [2:0] ram [8];

  ram_port_arbiter_if #(.AW(3), .DW(3)) bus ();

  ram_port_arbiter #(.AW(3), .DW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM preload is ~addr so every location starts non-zero.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 8; i++) ram[i] <= ~3'(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    ram_load = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    bus.clr_req = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",   32'(bus.clr_busy), 0);
    check("rst_done",   32'(bus.clr_done), 0);
    check("rst_arv",    32'(bus.a_rvalid), 0);
    check("rst_brv",    32'(bus.b_rvalid), 0);
    check("rst_ardata", 32'(bus.a_rdata),  0);
    check("rst_men",    32'(bus.mem_en),   0);
    @(negedge clk);
    rst = 1'b0; ram_load = 1'b0;

    // First contention: A then B, reads of 2 and 5
    bus.a_req = 1'b1; bus.a_addr = 3'd2;
    bus.b_req = 1'b1; bus.b_addr = 3'd5;
    #1;
    check("c0_agnt",  32'(bus.a_gnt),    1);
    check("c0_bgnt",  32'(bus.b_gnt),    0);
    check("c0_addr",  32'(bus.mem_addr), 2);
    check("c0_we",    32'(bus.mem_we),   0);
    check("c0_arv",   32'(bus.a_rvalid), 0);
    @(negedge clk);
    bus.a_req = 1'b0;
    #1;
    check("c1_bgnt",  32'(bus.b_gnt),    1);
    check("c1_agnt",  32'(bus.a_gnt),    0);
    check("c1_addr",  32'(bus.mem_addr), 5);
    check("c1_arv",   32'(bus.a_rvalid), 1);
    check("c1_ard",   32'(bus.a_rdata),  32'h5);
    @(negedge clk);
    bus.b_req = 1'b0;
    #1;
    check("c2_brv",   32'(bus.b_rvalid), 1);
    check("c2_brd",   32'(bus.b_rdata),  32'h2);
    check("c2_arv",   32'(bus.a_rvalid), 0);
    check("c2_men",   32'(bus.mem_en),   0);

    // Sustained contention alternates A,B,A,B,A,B
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_addr = 3'd1;
    bus.b_req = 1'b1; bus.b_addr = 3'd6;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_agnt", 32'(bus.a_gnt),  32'(k % 2 == 0));
      check("rr_bgnt", 32'(bus.b_gnt),  32'(k % 2 == 1));
      check("rr_men",  32'(bus.mem_en), 1);
      check("rr_arv",  32'(bus.a_rvalid), 32'(k > 0 && k % 2 == 1));
      check("rr_brv",  32'(bus.b_rvalid), 32'(k > 0 && k % 2 == 0));
      if (k > 0 && k % 2 == 1) check("rr_ard", 32'(bus.a_rdata), 32'h6);
      @(negedge clk);
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    #1;
    check("rr_brv_end", 32'(bus.b_rvalid), 1);
    check("rr_brd_end", 32'(bus.b_rdata),  32'h1);
    check("rr_men_end", 32'(bus.mem_en),   0);

    // A writes 3'b101 to 4 then reads it back
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 3'd4; bus.a_wdata = 3'b101;
    #1;
    check("wr_agnt",  32'(bus.a_gnt),     1);
    check("wr_we",    32'(bus.mem_we),    1);
    check("wr_addr",  32'(bus.mem_addr),  4);
    check("wr_wdata", 32'(bus.mem_wdata), 32'h5);
    @(negedge clk);
    bus.a_we = 1'b0;
    #1;
    check("rd_agnt",  32'(bus.a_gnt),    1);
    check("rd_we",    32'(bus.mem_we),   0);
    check("wr_norv",  32'(bus.a_rvalid), 0);
    check("wr_nord",  32'(bus.a_rdata),  0);
    @(negedge clk);
    bus.a_req = 1'b0;
    #1;
    check("rd_arv",   32'(bus.a_rvalid), 1);
    check("rd_ard",   32'(bus.a_rdata),  32'h5);

    // Clear requested while B reads 3; B's grant in that cycle completes
    @(negedge clk);
    bus.clr_req = 1'b1;
    bus.b_req = 1'b1; bus.b_addr = 3'd3;
    #1;
    check("cl_pre_bgnt", 32'(bus.b_gnt),    1);
    check("cl_pre_busy", 32'(bus.clr_busy), 0);
    check("cl_pre_addr", 32'(bus.mem_addr), 3);
    @(negedge clk);
    bus.clr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("cl_busy",  32'(bus.clr_busy),  1);
      check("cl_bgnt",  32'(bus.b_gnt),     0);
      check("cl_agnt",  32'(bus.a_gnt),     0);
      check("cl_men",   32'(bus.mem_en),    1);
      check("cl_we",    32'(bus.mem_we),    1);
      check("cl_addr",  32'(bus.mem_addr),  32'(i));
      check("cl_wdata", 32'(bus.mem_wdata), 0);
      check("cl_done",  32'(bus.clr_done),  32'(i == 7));
      check("cl_brv",   32'(bus.b_rvalid),  32'(i == 0));
      if (i == 0) check("cl_brd", 32'(bus.b_rdata), 32'h4);
      if (i == 2) bus.clr_req = 1'b1;
      if (i == 3) bus.clr_req = 1'b0;
      @(negedge clk);
    end
    #1;
    check("cl_post_busy", 32'(bus.clr_busy), 0);
    check("cl_post_done", 32'(bus.clr_done), 0);
    check("cl_post_bgnt", 32'(bus.b_gnt),    1);
    check("cl_post_addr", 32'(bus.mem_addr), 3);
    @(negedge clk);
    bus.b_req = 1'b0;
    bus.a_req = 1'b1; bus.a_addr = 3'd5;
    #1;
    check("cl_rd3_brv", 32'(bus.b_rvalid), 1);
    check("cl_rd3_brd", 32'(bus.b_rdata),  0);
    check("cl_rd5_gnt", 32'(bus.a_gnt),    1);
    check("cl_rd5_bsy", 32'(bus.clr_busy), 0);
    @(negedge clk);
    bus.a_req = 1'b0;
    #1;
    check("cl_rd5_arv", 32'(bus.a_rvalid), 1);
    check("cl_rd5_ard", 32'(bus.a_rdata),  0);

    // Reset during clear at address 3 aborts it
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(negedge clk);
    bus.clr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ab_addr", 32'(bus.mem_addr), 32'(i));
      check("ab_busy", 32'(bus.clr_busy), 1);
      if (i < 3) @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("ab_rst_busy", 32'(bus.clr_busy), 0);
    check("ab_rst_done", 32'(bus.clr_done), 0);
    check("ab_rst_men",  32'(bus.mem_en),   0);
    @(negedge clk);
    rst = 1'b0;
    bus.a_req = 1'b1; bus.a_addr = 3'd6;
    #1;
    check("ab_agnt", 32'(bus.a_gnt),    1);
    check("ab_busy2", 32'(bus.clr_busy), 0);
    check("ab_addr6", 32'(bus.mem_addr), 6);
    check("ab_done2", 32'(bus.clr_done), 0);
    @(negedge clk);
    bus.a_req = 1'b0;
    #1;
    check("ab_arv", 32'(bus.a_rvalid), 1);
    check("ab_ard", 32'(bus.a_rdata),  0);

    // Read in flight when reset hits is dropped
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_addr = 3'd4;
    #1;
    check("fl_agnt", 32'(bus.a_gnt), 1);
    @(negedge clk);
    bus.a_req = 1'b0;
    rst = 1'b1;
    #1;
    check("fl_arv", 32'(bus.a_rvalid), 0);
    check("fl_ard", 32'(bus.a_rdata),  0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("fl_arv2", 32'(bus.a_rvalid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
